// File: rtl/multicycle_proc.sv
// rtl/multicycle_proc.sv - multicycle LEGv8 core with req/ack instruction and data ports
// One shared ALU walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; register 31 reads as zero.
module multicycle_proc #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] currentpc,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B, OP_MOVZ, OP_ILL
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [XLEN-1:0]   rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;

  op_e               op;
  logic [4:0]        rd, rn, rm;
  logic [XLEN-1:0]   rn_val, rm_val, rt_val;
  logic [XLEN-1:0]   alu_res;
  logic [63:0]       movz_val;
  logic [ADDR_W-1:0] br_off, pc_seq;

  function automatic op_e decode_op(input logic [10:0] opc);
    casez (opc)
      11'b11111000010: return OP_LDUR;
      11'b11111000000: return OP_STUR;
      11'b10001011000: return OP_ADD;
      11'b11001011000: return OP_SUB;
      11'b10001010000: return OP_AND;
      11'b10101010000: return OP_ORR;
      11'b10110100???: return OP_CBZ;
      11'b000101?????: return OP_B;
      11'b110100101??: return OP_MOVZ;
      default:         return OP_ILL;
    endcase
  endfunction

  // IR is stable from DECODE onward, so fields are decoded straight from it
  always_comb begin
    op       = decode_op(ir_q[31:21]);
    rd       = ir_q[4:0];
    rn       = ir_q[9:5];
    rm       = ir_q[20:16];
    rn_val   = (rn == 5'd31) ? '0 : rf_q[rn];
    rm_val   = (rm == 5'd31) ? '0 : rf_q[rm];
    rt_val   = (rd == 5'd31) ? '0 : rf_q[rd];
    movz_val = 64'(ir_q[20:5]) << {ir_q[22:21], 4'b0000};
    br_off   = (op == OP_B) ? ADDR_W'($signed(ir_q[25:0])) : ADDR_W'($signed(ir_q[23:5]));
    pc_seq   = pc_q + ADDR_W'(4);
    case (op)
      OP_LDUR, OP_STUR: alu_res = a_q + imm_q;
      OP_SUB:           alu_res = a_q - b_q;
      OP_AND:           alu_res = a_q & b_q;
      OP_ORR:           alu_res = a_q | b_q;
      OP_MOVZ:          alu_res = imm_q;
      default:          alu_res = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_wa     = rd;
    rf_wd     = alu_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rn_val;
        b_d     = (op == OP_STUR || op == OP_CBZ) ? rt_val : rm_val;
        imm_d   = (op == OP_MOVZ) ? XLEN'(movz_val) : XLEN'($signed(ir_q[20:12]));
        state_d = (op == OP_ILL) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d = alu_res;
        case (op)
          OP_B, OP_CBZ: begin
            pc_d      = (op == OP_B || b_q == '0) ? pc_q + (br_off << 2) : pc_seq;
            retired_d = retired_q + 1'b1;
            state_d   = S_FETCH;
          end
          OP_LDUR, OP_STUR: state_d = S_MEMORY;
          default:          state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STUR);
        if (dmem_ack) begin
          if (op == OP_STUR) begin
            pc_d      = pc_seq;
            retired_d = retired_q + 1'b1;
            state_d   = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we     = (rd != 5'd31);
        rf_wd     = (op == OP_LDUR) ? mdr_q : alu_q;
        pc_d      = pc_seq;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
    // Requests are masked during reset so an in-flight access is dropped immediately
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= startpc;
      retired_q <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = ADDR_W'(alu_q);
  assign dmem_wdata = b_q;
  assign currentpc  = pc_q;
  assign halted     = (state_q == S_HALT);
  assign retired    = retired_q;
endmodule

// File: tb/tb_multicycle_proc.sv
// tb/tb_multicycle_proc.sv - scoreboard bench for multicycle_proc
// Fetch and data transactions are checked against queues filled by the stimulus.
module tb_multicycle_proc;
  logic        CLK = 1'b0;
  logic        reset;
  logic [63:0] startpc;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [63:0] currentpc;
  logic        halted;
  logic [31:0] retired;

  multicycle_proc dut (
    .CLK(CLK), .reset(reset), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .currentpc(currentpc), .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } dexp_t;

  int          total = 0;
  int          bad = 0;
  int          imem_delay, dmem_delay, icnt, dcnt;
  logic [31:0] imem [256];
  logic [63:0] dmem [16];
  logic [63:0] fq[$];
  dexp_t       dq[$];
  dexp_t       de;
  logic        pend, pwe, quiet;
  logic [63:0] pa, pw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory models respond 1 time unit after the falling edge
  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    icnt = 0; dcnt = 0;
    forever begin
      @(negedge CLK); #1;
      if (imem_req) begin
        if (icnt >= imem_delay) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr[9:2]]; icnt = 0;
        end else begin
          imem_ack = 1'b0; icnt++;
        end
      end else begin
        imem_ack = 1'b0; icnt = 0;
      end
      if (dmem_req) begin
        if (dcnt >= dmem_delay) begin
          dmem_ack = 1'b1; dmem_rdata = dmem[dmem_addr[6:3]]; dcnt = 0;
          if (dmem_we) dmem[dmem_addr[6:3]] = dmem_wdata;
        end else begin
          dmem_ack = 1'b0; dcnt++;
        end
      end else begin
        dmem_ack = 1'b0; dcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever a fetch or data access completes
  initial begin
    pend = 1'b0;
    forever begin
      @(negedge CLK); #2;
      if (imem_req && imem_ack) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_extra actual=%h required=none", imem_addr);
        end else chk("fetch_addr", imem_addr, fq.pop_front());
      end
      if (dmem_req) begin
        if (pend) chk("dmem_hold", 64'(dmem_addr !== pa || dmem_wdata !== pw || dmem_we !== pwe), 64'd0);
        pend = 1'b1; pa = dmem_addr; pw = dmem_wdata; pwe = dmem_we;
        if (dmem_ack) begin
          pend = 1'b0;
          if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL dmem_extra actual=%h required=none", dmem_addr);
          end else begin
            de = dq.pop_front();
            chk("dmem_we", 64'(dmem_we), 64'(de.we));
            chk("dmem_addr", dmem_addr, de.addr);
            if (de.we) chk("dmem_wdata", dmem_wdata, de.data);
          end
        end
      end else pend = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] FETCH1 [27] = '{
    64'h100, 64'h104, 64'h108, 64'h10C, 64'h110, 64'h114, 64'h118, 64'h11C, 64'h120,
    64'h124, 64'h128, 64'h12C, 64'h130, 64'h134, 64'h138, 64'h140, 64'h144, 64'h150,
    64'h154, 64'h148, 64'h14C, 64'h150, 64'h15C, 64'h160, 64'h164, 64'h168, 64'h16C};

  localparam logic [31:0] PROG1 [28] = '{
    32'hD28000A1, 32'hD28000E2, 32'h8B020023, 32'hF8008003, 32'hF8408004, 32'hF8010004,
    32'hCB010085, 32'h8A020066, 32'hAA010067, 32'hF8018005, 32'hF8020006, 32'hF8028007,
    32'hF85FC088, 32'hB4000083, 32'hB400005F, 32'hFFFFFFFF, 32'hD2800029, 32'h14000003,
    32'hD2800009, 32'hF8030009, 32'hB4000069, 32'hB4FFFFBF, 32'hFFFFFFFF, 32'hD2E2468A,
    32'hF803800A, 32'h8B02003F, 32'hF81FB03F, 32'hFFFFFFFF};

  initial begin
    reset = 1'b1; startpc = 64'h100; imem_delay = 0; dmem_delay = 3;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFFFFFF;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    for (int i = 0; i < 28; i++) imem[64 + i] = PROG1[i];
    imem[128] = 32'hF8408001;
    imem[192] = 32'hF8040001;
    for (int i = 0; i < 27; i++) fq.push_back(FETCH1[i]);
    dq.push_back('{1'b1, 64'd8,  64'd12});
    dq.push_back('{1'b0, 64'd8,  64'd0});
    dq.push_back('{1'b1, 64'd16, 64'd12});
    dq.push_back('{1'b1, 64'd24, 64'd7});
    dq.push_back('{1'b1, 64'd32, 64'd4});
    dq.push_back('{1'b1, 64'd40, 64'd13});
    dq.push_back('{1'b0, 64'd8,  64'd0});
    dq.push_back('{1'b1, 64'd48, 64'd0});
    dq.push_back('{1'b1, 64'd56, 64'h1234_0000_0000_0000});
    dq.push_back('{1'b1, 64'd0,  64'd0});

    repeat (3) @(negedge CLK);
    #3;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", currentpc, 64'h100);

    @(negedge CLK);
    reset = 1'b0;
    #3;
    chk("first_imem_req", 64'(imem_req), 64'd1);
    chk("first_imem_addr", imem_addr, 64'h100);
    repeat (12) @(negedge CLK);
    #3;
    chk("retired_12cyc", 64'(retired), 64'd3);
    chk("pc_12cyc", currentpc, 64'h10C);

    for (int i = 0; i < 3000 && !halted; i++) @(negedge CLK);
    #3;
    chk("halted", 64'(halted), 64'd1);
    chk("halt_pc", currentpc, 64'h16C);
    chk("halt_retired", 64'(retired), 64'd26);
    chk("fetch_q_empty", 64'(fq.size()), 64'd0);
    chk("dmem_q_empty", 64'(dq.size()), 64'd0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge CLK); #3;
      if (imem_req || dmem_req) quiet = 1'b0;
    end
    chk("halt_no_req", 64'(quiet), 64'd1);
    chk("halt_retired_frozen", 64'(retired), 64'd26);

    @(negedge CLK);
    reset = 1'b1; startpc = 64'h200; imem_delay = 2; dmem_delay = 50;
    fq.push_back(64'h200);
    @(negedge CLK); #3;
    chk("reset_clears_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 200 && !dmem_req; i++) @(negedge CLK);
    #3;
    chk("pending_dmem_req", 64'(dmem_req), 64'd1);
    chk("pending_dmem_addr", dmem_addr, 64'd8);
    repeat (3) @(negedge CLK);

    reset = 1'b1; startpc = 64'h300; dmem_delay = 1;
    fq.push_back(64'h300);
    fq.push_back(64'h304);
    dq.push_back('{1'b1, 64'd64, 64'd0});
    #3;
    chk("abandon_dmem_req", 64'(dmem_req), 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    #3;
    chk("abandon_retired", 64'(retired), 64'd0);
    chk("abandon_pc", currentpc, 64'h300);

    for (int i = 0; i < 500 && !halted; i++) @(negedge CLK);
    #3;
    chk("halted2", 64'(halted), 64'd1);
    chk("halt2_pc", currentpc, 64'h304);
    chk("halt2_retired", 64'(retired), 64'd1);
    chk("fetch_q_empty2", 64'(fq.size()), 64'd0);
    chk("dmem_q_empty2", 64'(dq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
